// File: rtl/pixel_fb_writer.sv
// Pixel-plot sink: buffers plot requests, clips off-screen pixels and writes the
// framebuffer one pixel per cycle; also sweeps the whole screen to a clear colour.
module pixel_fb_writer #(
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int CW    = 9,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int AW    = 15,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          plot,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [CW-1:0] colour,
  output logic          ready,
  input  logic          clear,
  input  logic [CW-1:0] bg_colour,
  output logic          busy,
  output logic          clear_done,
  output logic [AW-1:0] fb_addr,
  output logic [CW-1:0] fb_data,
  output logic          fb_wren,
  output logic [7:0]    clip_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [AW-1:0] SCR_W_A = AW'(SCR_W);
  localparam logic [AW-1:0] LAST    = AW'(SCR_W * SCR_H - 1);
  localparam logic [XW:0]   X_LIM   = (XW+1)'(SCR_W);
  localparam logic [YW:0]   Y_LIM   = (YW+1)'(SCR_H);
  localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] colour;
  } pix_t;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t        state, state_nx;
  pix_t          mem [DEPTH];
  pix_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nx;
  logic          push, pop, empty, in_range;
  logic [AW-1:0] sweep;
  logic [CW-1:0] bg;

  logic          wren_nx, clip_inc;
  logic [AW-1:0] addr_nx;
  logic [CW-1:0] data_nx;

  assign push     = plot && ready;
  assign empty    = (count == '0);
  // DRAIN keeps popping so queued pixels land before the sweep overwrites them
  assign pop      = (state != CLEAR) && !empty;
  assign head     = mem[rd_ptr];
  assign count_nx = count + (PW+1)'(push) - (PW+1)'(pop);
  assign in_range = ({1'b0, head.x} < X_LIM) && ({1'b0, head.y} < Y_LIM);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clear) state_nx = DRAIN;
      DRAIN:   if (empty) state_nx = CLEAR;
      CLEAR:   if (sweep == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wren_nx  = 1'b0;
    addr_nx  = fb_addr;
    data_nx  = fb_data;
    clip_inc = 1'b0;
    if (state == CLEAR) begin
      wren_nx = 1'b1;
      addr_nx = sweep;
      data_nx = bg;
    end else if (pop) begin
      if (in_range) begin
        wren_nx = 1'b1;
        addr_nx = AW'(head.y) * SCR_W_A + AW'(head.x);
        data_nx = head.colour;
      end else begin
        clip_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {x, y, colour};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      sweep      <= '0;
      bg         <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      fb_wren    <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      clip_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
      if (state == IDLE && clear) bg <= bg_colour;
      if (state == CLEAR) sweep <= sweep + 1'b1;
      else                sweep <= '0;
      // ready is registered from next-state values so it never depends on plot
      ready      <= (state_nx == IDLE) && (count_nx != FULL);
      busy       <= (state_nx != IDLE);
      clear_done <= (state == CLEAR) && (state_nx == IDLE);
      fb_wren    <= wren_nx;
      fb_addr    <= addr_nx;
      fb_data    <= data_nx;
      if (clip_inc && clip_cnt != 8'hFF) clip_cnt <= clip_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer; a queue scoreboard holds every expected framebuffer write.
module tb_pixel_fb_writer;

  localparam int NPIX = 160 * 120;

  logic        clk = 1'b0;
  logic        reset;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [8:0]  colour;
  logic        ready;
  logic        clear;
  logic [8:0]  bg_colour;
  logic        busy;
  logic        clear_done;
  logic [14:0] fb_addr;
  logic [8:0]  fb_data;
  logic        fb_wren;
  logic [7:0]  clip_cnt;

  typedef struct {
    logic [14:0] a;
    logic [8:0]  d;
  } wr_t;

  wr_t q[$];
  int  checks   = 0;
  int  failures = 0;
  int  done_cnt = 0;

  pixel_fb_writer dut (
    .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
    .ready(ready), .clear(clear), .bg_colour(bg_colour), .busy(busy),
    .clear_done(clear_done), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_wren(fb_wren), .clip_cnt(clip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write seen on the framebuffer port must match the queue head
  always @(negedge clk) begin
    if (clear_done) done_cnt++;
    if (!reset && fb_wren) begin
      check("sb_has_entry", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        wr_t e;
        e = q.pop_front();
        check("sb_addr", 32'(fb_addr), 32'(e.a));
        check("sb_data", 32'(fb_data), 32'(e.d));
      end
    end
  end

  function automatic logic on_screen(input int px, input int py);
    return (px < 160) && (py < 120);
  endfunction

  task automatic expect_pix(input int px, input int py, input logic [8:0] c);
    wr_t e;
    if (on_screen(px, py)) begin
      e.a = 15'(py * 160 + px);
      e.d = c;
      q.push_back(e);
    end
  endtask

  // hold the request until accepted (bounded), then drop plot
  task automatic do_plot(input int px, input int py, input logic [8:0] c);
    logic acc;
    acc = 1'b0;
    plot = 1'b1; x = 8'(px); y = 7'(py); colour = c;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = ready;
      @(posedge clk);
      #1;
    end
    check("plot_accepted", 32'(acc), 32'd1);
    if (acc) expect_pix(px, py, c);
    plot = 1'b0;
  endtask

  task automatic plot_latency(input int px, input int py, input logic [8:0] c);
    do_plot(px, py, c);
    check("lat_wren_e0", 32'(fb_wren), 32'd0);
    @(posedge clk); #1;
    check("lat_wren_e1", 32'(fb_wren), 32'd1);
    check("lat_addr", 32'(fb_addr), 32'(py * 160 + px));
    check("lat_data", 32'(fb_data), 32'(c));
    @(posedge clk); #1;
    check("lat_wren_e2", 32'(fb_wren), 32'd0);
  endtask

  task automatic start_clear(input logic [8:0] c);
    wr_t e;
    clear = 1'b1; bg_colour = c;
    for (int i = 0; i < NPIX; i++) begin
      e.a = 15'(i);
      e.d = c;
      q.push_back(e);
    end
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < NPIX + 200 && !got; i++) begin
      @(posedge clk); #1;
      got = clear_done;
    end
    check(tag, 32'(got), 32'd1);
  endtask

  initial begin
    reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
    clear = 1'b0; bg_colour = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wren", 32'(fb_wren), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_data", 32'(fb_data), 32'd0);
    check("rst_clip", 32'(clip_cnt), 32'd0);
    check("rst_done", 32'(clear_done), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_before_edge", 32'(ready), 32'd0);
    @(posedge clk); #1;
    check("ready_after_edge", 32'(ready), 32'd1);

    // single plot with latency
    plot_latency(3, 2, 9'h1C0);

    // back-to-back plots: ready must stay high
    for (int i = 0; i < 6; i++) begin
      plot = 1'b1; x = 8'(i); y = '0; colour = 9'(16 + i);
      check("b2b_ready", 32'(ready), 32'd1);
      expect_pix(i, 0, 9'(16 + i));
      @(posedge clk); #1;
    end
    plot = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b2b_drained", 32'(q.size()), 32'd0);

    // clipping
    do_plot(160, 0, 9'h011);
    do_plot(0, 120, 9'h022);
    do_plot(159, 119, 9'h033);
    repeat (4) @(posedge clk);
    #1;
    check("clip_two", 32'(clip_cnt), 32'd2);
    check("clip_sb_empty", 32'(q.size()), 32'd0);
    for (int i = 0; i < 260; i++) do_plot(200 + (i % 50), i % 128, 9'h0AA);
    repeat (4) @(posedge clk);
    #1;
    check("clip_saturate", 32'(clip_cnt), 32'd255);

    // clear with queued pixels; plot on the clear edge is still accepted
    plot = 1'b1; x = 8'd10; y = 7'd1; colour = 9'h101;
    expect_pix(10, 1, 9'h101); @(posedge clk); #1;
    x = 8'd11; colour = 9'h102;
    expect_pix(11, 1, 9'h102); @(posedge clk); #1;
    x = 8'd12; colour = 9'h103;
    check("clr_plot_ready", 32'(ready), 32'd1);
    expect_pix(12, 1, 9'h103);
    start_clear(9'h007);
    plot = 1'b0;
    check("clr_ready_low", 32'(ready), 32'd0);
    check("clr_busy_start", 32'(busy), 32'd1);
    repeat (5000) @(posedge clk);
    #1;
    check("clr_busy_mid", 32'(busy), 32'd1);
    check("clr_ready_mid", 32'(ready), 32'd0);
    wait_done("clr_done_seen");
    check("clr_ready_back", 32'(ready), 32'd1);
    check("clr_busy_off", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("clr_done_pulse1", 32'(clear_done), 32'd0);
    check("clr_sb_empty", 32'(q.size()), 32'd0);
    check("clr_done_cnt", 32'(done_cnt), 32'd1);

    // second clear mid-sweep is ignored
    start_clear(9'h1F0);
    repeat (1000) @(posedge clk);
    #1;
    clear = 1'b1; bg_colour = 9'h055;
    @(posedge clk); #1;
    clear = 1'b0;
    wait_done("ign_done_seen");
    repeat (4) @(posedge clk);
    #1;
    check("ign_sb_empty", 32'(q.size()), 32'd0);
    check("ign_done_cnt", 32'(done_cnt), 32'd2);

    // reset mid-sweep
    start_clear(9'h0F0);
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NPIX && !hit; i++) begin
        @(posedge clk); #1;
        hit = fb_wren && (fb_addr == 15'd5000);
      end
      check("rst_mid_reached", 32'(hit), 32'd1);
    end
    reset = 1'b1;
    q.delete();
    #1;
    check("rmid_wren", 32'(fb_wren), 32'd0);
    check("rmid_addr", 32'(fb_addr), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_ready", 32'(ready), 32'd0);
    check("rmid_clip", 32'(clip_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rmid_no_done", 32'(done_cnt), 32'd2);
    plot_latency(1, 1, 9'h1FF);
    repeat (3) @(posedge clk);
    #1;
    check("final_sb_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
